// File: rtl/fetch_unit_pkg.sv
// Shared constants, types and helpers for the instruction fetch stage.
package fetch_unit_pkg;

    localparam int unsigned WORD_W = 32;
    localparam int unsigned JIDX_W = 26;
    localparam int unsigned PC_TOP_W = 4;

    typedef logic [WORD_W-1:0] word_t;

    localparam word_t RESET_PC_DEFAULT = 32'h0000_0000;
    localparam word_t NOP_INSTR        = 32'h0000_0000;
    localparam word_t PC_INC           = 32'd4;
    localparam word_t PC_ALIGN_MASK    = 32'hFFFF_FFFC;

    // IF/ID pipeline register payload
    typedef struct packed {
        word_t instr;
        word_t pc_plus4;
        logic  valid;
    } ifid_t;

    localparam ifid_t IFID_BUBBLE = '{instr: NOP_INSTR, pc_plus4: '0, valid: 1'b0};

    // Forces word alignment of a byte address.
    function automatic word_t align_word(input word_t addr);
        return addr & PC_ALIGN_MASK;
    endfunction

endpackage

// File: rtl/fetch_unit_if.sv
// Fetch-stage bus: instruction-memory port, hazard/redirect controls and IF/ID outputs.
interface fetch_unit_if;
    import fetch_unit_pkg::*;

    word_t               Address;
    word_t               Instruction;
    logic                Stall;
    logic                BranchTaken;
    word_t               BranchTarget;
    logic                Jump;
    logic [JIDX_W-1:0]   JumpIndex;
    word_t               IfIdInstr;
    word_t               IfIdPcPlus4;
    logic                IfIdValid;
    word_t               FetchCount;

    // Fetch unit side
    modport master (
        output Address, IfIdInstr, IfIdPcPlus4, IfIdValid, FetchCount,
        input  Instruction, Stall, BranchTaken, BranchTarget, Jump, JumpIndex
    );

    // Memory / pipeline / hazard side
    modport slave (
        input  Address, IfIdInstr, IfIdPcPlus4, IfIdValid, FetchCount,
        output Instruction, Stall, BranchTaken, BranchTarget, Jump, JumpIndex
    );

endinterface

// File: rtl/fetch_unit_program_counter.sv
// PC register with next-PC selection: branch, then jump, then stall hold, then PC+4.
module program_counter
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                stall_i,
    input  logic                branch_taken_i,
    input  word_t               branch_target_i,
    input  logic                jump_i,
    input  logic [JIDX_W-1:0]   jump_index_i,
    input  logic [PC_TOP_W-1:0] ifid_pc_top_i,
    output word_t               pc_o
);

    word_t pc_q;
    word_t pc_d;

    // Next-PC priority mux; PC+4 wraps naturally at 2^32
    always_comb begin
        pc_d = pc_q;
        if (branch_taken_i) begin
            pc_d = align_word(branch_target_i);
        end else if (jump_i) begin
            pc_d = {ifid_pc_top_i, jump_index_i, 2'b00};
        end else if (!stall_i) begin
            pc_d = WORD_W'(pc_q + PC_INC);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q <= align_word(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    assign pc_o = pc_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC sequencing, IF/ID register and delivered-instruction counter.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter word_t RESET_PC = RESET_PC_DEFAULT
) (
    input  logic          Clk,
    input  logic          Rst_n,
    fetch_unit_if.master  bus
);

    word_t pc;
    ifid_t ifid_q;
    ifid_t ifid_d;
    word_t count_q;
    word_t count_d;
    logic  redirect;

    program_counter #(
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk             (Clk),
        .rst_n           (Rst_n),
        .stall_i         (bus.Stall),
        .branch_taken_i  (bus.BranchTaken),
        .branch_target_i (bus.BranchTarget),
        .jump_i          (bus.Jump),
        .jump_index_i    (bus.JumpIndex),
        .ifid_pc_top_i   (ifid_q.pc_plus4[WORD_W-1 -: PC_TOP_W]),
        .pc_o            (pc)
    );

    assign redirect = bus.BranchTaken | bus.Jump;

    // A redirect squashes the fetched word even while stalled
    always_comb begin
        ifid_d  = ifid_q;
        count_d = count_q;
        if (redirect) begin
            ifid_d = IFID_BUBBLE;
        end else if (!bus.Stall) begin
            ifid_d.instr    = bus.Instruction;
            ifid_d.pc_plus4 = WORD_W'(pc + PC_INC);
            ifid_d.valid    = 1'b1;
            count_d         = WORD_W'(count_q + 32'd1);
        end
    end

    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            ifid_q  <= IFID_BUBBLE;
            count_q <= '0;
        end else begin
            ifid_q  <= ifid_d;
            count_q <= count_d;
        end
    end

    assign bus.Address     = pc;
    assign bus.IfIdInstr   = ifid_q.instr;
    assign bus.IfIdPcPlus4 = ifid_q.pc_plus4;
    assign bus.IfIdValid   = ifid_q.valid;
    assign bus.FetchCount  = count_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed and randomized bench for fetch_unit against a cycle-level reference model.
module tb_fetch_unit;

    logic Clk;
    logic Rst_n;
    fetch_unit_if bus ();

    fetch_unit #(.RESET_PC(32'h0000_0000)) dut (
        .Clk   (Clk),
        .Rst_n (Rst_n),
        .bus   (bus)
    );

    int n_vec = 0;
    int n_err = 0;

    // Reference state: what the fetch stage should hold after each edge
    logic [31:0] m_pc, m_instr, m_p4, m_cnt;
    logic        m_v;

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    // Instruction memory: two fixed program words, hashed contents elsewhere
    function automatic logic [31:0] mem_read(input logic [31:0] a);
        case (a)
            32'h0000_0000: return 32'h2008_0002;
            32'h0000_0004: return 32'h2109_0004;
            default:       return (a * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
        endcase
    endfunction

    always_comb bus.Instruction = mem_read(bus.Address);

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".Address"},     bus.Address,            m_pc);
        chk({tag, ".IfIdInstr"},   bus.IfIdInstr,          m_instr);
        chk({tag, ".IfIdPcPlus4"}, bus.IfIdPcPlus4,        m_p4);
        chk({tag, ".IfIdValid"},   32'(bus.IfIdValid),     32'(m_v));
        chk({tag, ".FetchCount"},  bus.FetchCount,         m_cnt);
    endtask

    // One clock: drive at negedge, advance the model, check 1 time unit after posedge
    task automatic cycle(input string tag, input logic rst, input logic st, input logic br,
                         input logic [31:0] tgt, input logic j, input logic [25:0] jidx);
        logic [31:0] n_pc, n_instr, n_p4, n_cnt;
        logic        n_v;
        @(negedge Clk);
        Rst_n            = ~rst;
        bus.Stall        = st;
        bus.BranchTaken  = br;
        bus.BranchTarget = tgt;
        bus.Jump         = j;
        bus.JumpIndex    = jidx;
        n_pc = m_pc; n_instr = m_instr; n_p4 = m_p4; n_v = m_v; n_cnt = m_cnt;
        if (rst) begin
            n_pc = 32'h0; n_instr = 32'h0; n_p4 = 32'h0; n_v = 1'b0; n_cnt = 32'h0;
        end else begin
            if (br)       n_pc = tgt - (tgt % 4);
            else if (j)   n_pc = (m_p4 & 32'hF000_0000) + (32'(jidx) * 4);
            else if (!st) n_pc = m_pc + 4;
            if (br || j) begin
                n_instr = 32'h0; n_p4 = 32'h0; n_v = 1'b0;
            end else if (!st) begin
                n_instr = mem_read(m_pc); n_p4 = m_pc + 4; n_v = 1'b1; n_cnt = m_cnt + 1;
            end
        end
        @(posedge Clk);
        #1;
        m_pc = n_pc; m_instr = n_instr; m_p4 = n_p4; m_v = n_v; m_cnt = n_cnt;
        chk_model(tag);
    endtask

    initial begin
        logic [31:0] tgt;
        int          r;
        Rst_n = 1'b0;
        bus.Stall = 1'b0; bus.BranchTaken = 1'b0; bus.BranchTarget = '0;
        bus.Jump = 1'b0; bus.JumpIndex = '0;
        m_pc = '0; m_instr = '0; m_p4 = '0; m_v = 1'b0; m_cnt = '0;

        // Reset, then free-running fetch of the two program words
        cycle("rst0", 1, 0, 0, 0, 0, 0);
        cycle("rst1", 1, 1, 1, 32'h44, 1, 26'h3);
        chk("rst_addr", bus.Address, 32'h0);
        chk("rst_valid", 32'(bus.IfIdValid), 32'h0);
        cycle("free1", 0, 0, 0, 0, 0, 0);
        chk("free1_addr", bus.Address, 32'h4);
        chk("free1_instr", bus.IfIdInstr, 32'h2008_0002);
        cycle("free2", 0, 0, 0, 0, 0, 0);
        chk("free2_addr", bus.Address, 32'h8);
        chk("free2_instr", bus.IfIdInstr, 32'h2109_0004);
        chk("free2_cnt", bus.FetchCount, 32'd2);

        // Stall holds PC and IF/ID for two cycles, then resumes
        cycle("stall1", 0, 1, 0, 0, 0, 0);
        cycle("stall2", 0, 1, 0, 0, 0, 0);
        chk("stall_addr", bus.Address, 32'h8);
        chk("stall_cnt", bus.FetchCount, 32'd2);
        cycle("resume", 0, 0, 0, 0, 0, 0);
        chk("resume_addr", bus.Address, 32'hC);

        // Branch during stall: aligned target, bubble, count held
        cycle("br_stall", 0, 1, 1, 32'h43, 0, 0);
        chk("br_addr", bus.Address, 32'h40);
        chk("br_valid", 32'(bus.IfIdValid), 32'h0);
        chk("br_cnt", bus.FetchCount, 32'd3);

        // Branch beats jump; jump alone uses IfIdPcPlus4[31:28]
        cycle("to_hi", 0, 0, 1, 32'h1000_0004, 0, 0);
        cycle("hi_free", 0, 0, 0, 0, 0, 0);
        chk("hi_p4", bus.IfIdPcPlus4, 32'h1000_0008);
        cycle("br_jmp", 0, 0, 1, 32'h20, 1, 26'h10);
        chk("brjmp_addr", bus.Address, 32'h20);
        chk("brjmp_valid", 32'(bus.IfIdValid), 32'h0);
        cycle("to_hi2", 0, 0, 1, 32'h1000_0004, 0, 0);
        cycle("hi_free2", 0, 0, 0, 0, 0, 0);
        cycle("jmp", 0, 0, 0, 0, 1, 26'h10);
        chk("jmp_addr", bus.Address, 32'h1000_0040);

        // PC wrap, then reset asserted during stall
        cycle("to_top", 0, 0, 1, 32'hFFFF_FFFC, 0, 0);
        cycle("wrap", 0, 0, 0, 0, 0, 0);
        chk("wrap_addr", bus.Address, 32'h0);
        chk("wrap_p4", bus.IfIdPcPlus4, 32'h0);
        cycle("pre_rst", 0, 1, 0, 0, 0, 0);
        cycle("rst_stall", 1, 1, 0, 0, 0, 0);
        chk("rst_stall_addr", bus.Address, 32'h0);
        chk("rst_stall_cnt", bus.FetchCount, 32'h0);
        cycle("post_rst", 0, 0, 0, 0, 0, 0);
        chk("post_rst_instr", bus.IfIdInstr, 32'h2008_0002);

        // Randomized traffic
        for (int i = 0; i < 400; i++) begin
            r   = $urandom_range(0, 99);
            tgt = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 + 32'($urandom_range(0, 7)) : $urandom;
            cycle("rnd", r < 3, $urandom_range(0, 99) < 30, (r >= 3) && (r < 13), tgt,
                  $urandom_range(0, 99) < 10, 26'($urandom));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
